// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants and the hazard sequencer state type
// shared by the pipeline control logic.
package mips_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned REG_W   = 5;

   localparam logic [OP_W-1:0]    OP_SPECIAL  = 6'h00;
   localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
   localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
   localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
   localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUSY   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } hazard_state_t;

   // True for the four SPECIAL functs that occupy the mult/div unit.
   function automatic logic is_muldiv_funct(input logic [FUNCT_W-1:0] funct);
      return (funct == FUNCT_MULT)  || (funct == FUNCT_MULTU) ||
             (funct == FUNCT_DIV)   || (funct == FUNCT_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_busy_counter.sv
// muldiv_busy_counter: remaining-cycle counter for the mult/div unit.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset (clears to 0)
//   load_i          - load load_value_i (has priority over dec_i)
//   load_value_i    - value to load
//   dec_i           - decrement by one; saturates at 0, never wraps
//   zero_o          - count is 0
module muldiv_busy_counter #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_value_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load wins, decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_value_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the 5-stage pipeline.
// Detects load-use hazards, sequences the multi-cycle mult/div unit behind
// HI/LO, and freezes the pipeline after HALT.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   Rs_decode, Rt_decode       - decode source registers
//   using_HI_LO_decode         - decode instruction touches HI/LO
//   register_write_execute     - execute instruction writes the RF
//   memory_to_register_execute - execute instruction is a load
//   write_register_execute     - execute destination register
//   op_execute, ALU_function_execute - execute opcode / funct
//   HALT_execute               - HALT in execute
//   stall_fetch, stall_decode  - hold PC / fetch-decode register
//   clear_decode_execute       - bubble into decode/execute
//   muldiv_start, muldiv_is_div - unit start strobe and divide select
//   hi_lo_busy                 - unit occupied
//   active                     - 0 once halted
// All outputs are combinational from the state and current inputs.
module pipeline_hazard_controller
   import mips_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [REG_W-1:0]   Rs_decode,
   input  logic [REG_W-1:0]   Rt_decode,
   input  logic               using_HI_LO_decode,
   input  logic               register_write_execute,
   input  logic               memory_to_register_execute,
   input  logic [REG_W-1:0]   write_register_execute,
   input  logic [OP_W-1:0]    op_execute,
   input  logic [FUNCT_W-1:0] ALU_function_execute,
   input  logic               HALT_execute,
   output logic               stall_fetch,
   output logic               stall_decode,
   output logic               clear_decode_execute,
   output logic               muldiv_start,
   output logic               muldiv_is_div,
   output logic               hi_lo_busy,
   output logic               active
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   hazard_state_t    state_q;
   logic             cnt_zero;
   logic             halted;
   logic             load_use;
   logic             hi_lo_hazard;
   logic [CNT_W-1:0] load_value;

   // Mult/div detection and strobe; only RUN may launch a new operation.
   always_comb begin
      muldiv_start  = (op_execute == OP_SPECIAL) &&
                      is_muldiv_funct(ALU_function_execute) &&
                      (state_q == ST_RUN);
      muldiv_is_div = ALU_function_execute[1];
      load_value    = muldiv_is_div ? DIV_LOAD : MULT_LOAD;
   end

   // Hazard detection and stall/clear generation; HALTED overrides all.
   always_comb begin
      halted       = (state_q == ST_HALTED);
      hi_lo_busy   = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
      active       = !halted;
      load_use     = memory_to_register_execute && register_write_execute &&
                     (write_register_execute != '0) &&
                     ((write_register_execute == Rs_decode) ||
                      (write_register_execute == Rt_decode));
      // Counter at 0 means HI/LO is written this cycle, so a reader may proceed.
      hi_lo_hazard = using_HI_LO_decode && (muldiv_start || (hi_lo_busy && !cnt_zero));
      stall_fetch          = halted || load_use || hi_lo_hazard;
      stall_decode         = stall_fetch;
      clear_decode_execute = stall_fetch;
   end

   muldiv_busy_counter #(
      .CNT_W (CNT_W)
   ) u_busy_counter (
      .clk          (clk),
      .reset        (reset),
      .load_i       (muldiv_start),
      .load_value_i (load_value),
      .dec_i        (hi_lo_busy),
      .zero_o       (cnt_zero)
   );

   // Sequencer state. A HALT during BUSY with the count already at 0 goes
   // straight to HALTED so the drain always takes count+1 cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (muldiv_start) begin
                  state_q <= ST_BUSY;
               end else if (HALT_execute) begin
                  state_q <= ST_HALTED;
               end
            end
            ST_BUSY: begin
               if (cnt_zero) begin
                  state_q <= HALT_execute ? ST_HALTED : ST_RUN;
               end else if (HALT_execute) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (cnt_zero) begin
                  state_q <= ST_HALTED;
               end
            end
            ST_HALTED: begin
               state_q <= ST_HALTED;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors for the hazard sequencer
// (defaults MULT_CYCLES=4, DIV_CYCLES=32). Inputs change on the falling
// edge; outputs are sampled 1 ns later, within the same cycle.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs_decode;
   logic [4:0] Rt_decode;
   logic       using_HI_LO_decode;
   logic       register_write_execute;
   logic       memory_to_register_execute;
   logic [4:0] write_register_execute;
   logic [5:0] op_execute;
   logic [5:0] ALU_function_execute;
   logic       HALT_execute;
   logic       stall_fetch;
   logic       stall_decode;
   logic       clear_decode_execute;
   logic       muldiv_start;
   logic       muldiv_is_div;
   logic       hi_lo_busy;
   logic       active;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(
      .MULT_CYCLES (4),
      .DIV_CYCLES  (32)
   ) dut (
      .clk                        (clk),
      .reset                      (reset),
      .Rs_decode                  (Rs_decode),
      .Rt_decode                  (Rt_decode),
      .using_HI_LO_decode         (using_HI_LO_decode),
      .register_write_execute     (register_write_execute),
      .memory_to_register_execute (memory_to_register_execute),
      .write_register_execute     (write_register_execute),
      .op_execute                 (op_execute),
      .ALU_function_execute       (ALU_function_execute),
      .HALT_execute               (HALT_execute),
      .stall_fetch                (stall_fetch),
      .stall_decode               (stall_decode),
      .clear_decode_execute       (clear_decode_execute),
      .muldiv_start               (muldiv_start),
      .muldiv_is_div              (muldiv_is_div),
      .hi_lo_busy                 (hi_lo_busy),
      .active                     (active)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Stall, decode hold and clear must move together.
   task automatic chk_stall(input string tag, input logic exp);
      chk(tag, 32'({stall_fetch, stall_decode, clear_decode_execute}),
          exp ? 32'd7 : 32'd0);
   endtask

   task automatic quiet();
      Rs_decode                  = 5'd0;
      Rt_decode                  = 5'd0;
      using_HI_LO_decode         = 1'b0;
      register_write_execute     = 1'b0;
      memory_to_register_execute = 1'b0;
      write_register_execute     = 5'd0;
      op_execute                 = 6'd0;
      ALU_function_execute       = 6'd0;
      HALT_execute               = 1'b0;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic load_use_inputs(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt);
      memory_to_register_execute = 1'b1;
      register_write_execute     = 1'b1;
      write_register_execute     = wr;
      Rs_decode                  = rs;
      Rt_decode                  = rt;
   endtask

   initial begin
      reset = 1'b1;
      quiet();
      #1;
      // Reset state with quiet inputs.
      chk_stall("rst_stall", 1'b0);
      chk("rst_start", 32'(muldiv_start), 32'd0);
      chk("rst_active", 32'(active), 32'd1);
      chk("rst_busy", 32'(hi_lo_busy), 32'd0);
      // During reset the RUN rules still apply to the inputs.
      load_use_inputs(5'd5, 5'd5, 5'd0);
      #1;
      chk_stall("rst_loaduse", 1'b1);

      // Load-use: one cycle of stall, then the bubble clears it.
      next_cycle();
      reset = 1'b0;
      quiet();
      load_use_inputs(5'd5, 5'd5, 5'd0);
      #1;
      chk_stall("lu_rs", 1'b1);
      next_cycle();
      quiet();
      Rs_decode = 5'd5;
      #1;
      chk_stall("lu_after", 1'b0);
      next_cycle();
      load_use_inputs(5'd7, 5'd1, 5'd7);
      #1;
      chk_stall("lu_rt", 1'b1);
      next_cycle();
      load_use_inputs(5'd0, 5'd0, 5'd0);
      #1;
      chk_stall("lu_r0", 1'b0);
      next_cycle();
      load_use_inputs(5'd5, 5'd5, 5'd0);
      memory_to_register_execute = 1'b0;
      #1;
      chk_stall("lu_noload", 1'b0);
      next_cycle();
      load_use_inputs(5'd5, 5'd6, 5'd4);
      #1;
      chk_stall("lu_nomatch", 1'b0);

      // DIV at t with MFHI held in decode.
      next_cycle();
      quiet();
      ALU_function_execute = 6'h1A;
      using_HI_LO_decode   = 1'b1;
      #1;
      chk("div_start", 32'(muldiv_start), 32'd1);
      chk("div_isdiv", 32'(muldiv_is_div), 32'd1);
      chk_stall("div_stall_t", 1'b1);
      chk("div_busy_t", 32'(hi_lo_busy), 32'd0);
      for (int i = 1; i <= 31; i++) begin
         next_cycle();
         ALU_function_execute = 6'h00;
         #1;
         chk_stall("div_stall", 1'b1);
         chk("div_busy", 32'(hi_lo_busy), 32'd1);
         chk("div_nostart", 32'(muldiv_start), 32'd0);
      end
      next_cycle();
      #1;
      chk_stall("div_release", 1'b0);
      chk("div_busy_t32", 32'(hi_lo_busy), 32'd1);
      next_cycle();
      using_HI_LO_decode = 1'b0;
      #1;
      chk("div_busy_t33", 32'(hi_lo_busy), 32'd0);

      // MULT with an unrelated ADD in decode: no stall, busy 4 cycles.
      next_cycle();
      quiet();
      ALU_function_execute = 6'h18;
      Rs_decode            = 5'd3;
      #1;
      chk("mul_start", 32'(muldiv_start), 32'd1);
      chk("mul_isdiv", 32'(muldiv_is_div), 32'd0);
      chk_stall("mul_stall_t", 1'b0);
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         ALU_function_execute = 6'h20;
         #1;
         chk("mul_busy", 32'(hi_lo_busy), 32'd1);
         chk_stall("mul_nostall", 1'b0);
      end
      next_cycle();
      #1;
      chk("mul_done", 32'(hi_lo_busy), 32'd0);

      // MULTU, then load-use plus MFLO together while busy.
      next_cycle();
      quiet();
      ALU_function_execute = 6'h19;
      #1;
      chk("mulu_start", 32'(muldiv_start), 32'd1);
      next_cycle();
      quiet();
      using_HI_LO_decode = 1'b1;
      load_use_inputs(5'd9, 5'd9, 5'd9);
      #1;
      chk_stall("merge_both", 1'b1);
      next_cycle();
      quiet();
      using_HI_LO_decode = 1'b1;
      #1;
      chk_stall("merge_cnt2", 1'b1);
      next_cycle();
      #1;
      chk_stall("merge_cnt1", 1'b1);
      next_cycle();
      #1;
      chk_stall("merge_cnt0", 1'b0);
      chk("merge_busy", 32'(hi_lo_busy), 32'd1);
      next_cycle();
      quiet();
      #1;
      chk("merge_done", 32'(hi_lo_busy), 32'd0);

      // DIV, HALT at counter 5 (cycle t+27): HALTED at t+33.
      next_cycle();
      quiet();
      ALU_function_execute = 6'h1B;
      #1;
      chk("divu_start", 32'(muldiv_start), 32'd1);
      chk("divu_isdiv", 32'(muldiv_is_div), 32'd1);
      for (int i = 1; i <= 27; i++) begin
         next_cycle();
         quiet();
         if (i == 27) HALT_execute = 1'b1;
         #1;
         chk("halt_busy", 32'(hi_lo_busy), 32'd1);
      end
      for (int i = 28; i <= 32; i++) begin
         next_cycle();
         quiet();
         #1;
         chk("drain_active", 32'(active), 32'd1);
         chk("drain_busy", 32'(hi_lo_busy), 32'd1);
         chk_stall("drain_stall", 1'b0);
      end
      for (int i = 33; i <= 36; i++) begin
         next_cycle();
         quiet();
         ALU_function_execute = 6'h18;
         #1;
         chk("halted_active", 32'(active), 32'd0);
         chk("halted_busy", 32'(hi_lo_busy), 32'd0);
         chk_stall("halted_stall", 1'b1);
         chk("halted_nostart", 32'(muldiv_start), 32'd0);
      end

      // Asynchronous reset leaves HALTED at once.
      next_cycle();
      quiet();
      reset = 1'b1;
      #1;
      chk("rst_halt_active", 32'(active), 32'd1);
      chk_stall("rst_halt_stall", 1'b0);
      next_cycle();
      reset = 1'b0;

      // Reset mid-DIV at counter 10 (cycle t+22).
      ALU_function_execute = 6'h1A;
      #1;
      chk("rdiv_start", 32'(muldiv_start), 32'd1);
      for (int i = 1; i <= 21; i++) begin
         next_cycle();
         quiet();
      end
      next_cycle();
      #1;
      chk("rdiv_busy_pre", 32'(hi_lo_busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("rdiv_busy", 32'(hi_lo_busy), 32'd0);
      chk("rdiv_nostart", 32'(muldiv_start), 32'd0);
      chk_stall("rdiv_stall", 1'b0);
      chk("rdiv_active", 32'(active), 32'd1);
      next_cycle();
      reset = 1'b0;
      ALU_function_execute = 6'h18;
      using_HI_LO_decode   = 1'b1;
      #1;
      chk("rmul_start", 32'(muldiv_start), 32'd1);
      chk_stall("rmul_stall_t", 1'b1);
      for (int i = 1; i <= 3; i++) begin
         next_cycle();
         ALU_function_execute = 6'h00;
         #1;
         chk("rmul_busy", 32'(hi_lo_busy), 32'd1);
         chk_stall("rmul_stall", 1'b1);
      end
      next_cycle();
      #1;
      chk("rmul_busy4", 32'(hi_lo_busy), 32'd1);
      chk_stall("rmul_release", 1'b0);
      next_cycle();
      quiet();
      #1;
      chk("rmul_done", 32'(hi_lo_busy), 32'd0);

      // HALT from RUN takes effect on the next edge.
      next_cycle();
      HALT_execute = 1'b1;
      #1;
      chk("run_halt_active", 32'(active), 32'd1);
      next_cycle();
      quiet();
      #1;
      chk("run_halted", 32'(active), 32'd0);
      chk_stall("run_halted_stall", 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
